// File: rtl/ifetch.sv
// Instruction fetch unit: holds the PC, captures memory words with their PC
// into a small FIFO, and hands entries to decode over valid/ready.
// Optional performance counters are enabled by defining IFETCH_PERF_CNT_EN.
module ifetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        ip_clk,
   input  logic        ip_reset,
   input  logic        ip_fetch_en,
   output logic [31:0] op_inst_addr,
   input  logic        ip_inst_valid,
   input  logic [31:0] ip_inst_from_imem,
   input  logic        ip_redirect_valid,
   input  logic [31:0] ip_redirect_pc,
   output logic        op_dec_valid,
   output logic [31:0] op_dec_inst,
   output logic [31:0] op_dec_pc,
`ifdef IFETCH_PERF_CNT_EN
   output logic [31:0] op_fetch_count,
   output logic [31:0] op_stall_count,
`endif
   input  logic        ip_dec_ready
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [PW:0]   count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   buf_pc_q   [FIFO_DEPTH];
   logic [31:0]   buf_pc_d   [FIFO_DEPTH];
   logic [31:0]   buf_inst_q [FIFO_DEPTH];
   logic [31:0]   buf_inst_d [FIFO_DEPTH];
   logic          push;
   logic          pop;
   logic          unused_redirect_lsb;

   assign unused_redirect_lsb = ^ip_redirect_pc[1:0];

   assign op_inst_addr = pc_q;
   assign op_dec_valid = (count_q != '0);
   assign op_dec_inst  = buf_inst_q[rd_ptr_q];
   assign op_dec_pc    = buf_pc_q[rd_ptr_q];

   // Fetch/flush control: redirect wins over push; pop never frees space for
   // the same cycle's push because push looks at the registered count.
   always_comb begin
      push       = ip_fetch_en & ip_inst_valid & (count_q < DEPTH_C) & ~ip_redirect_valid;
      pop        = op_dec_valid & ip_dec_ready;
      pc_d       = pc_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      buf_pc_d   = buf_pc_q;
      buf_inst_d = buf_inst_q;
      if (ip_redirect_valid) begin
         pc_d     = {ip_redirect_pc[31:2], 2'b00};
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) begin
            buf_pc_d[wr_ptr_q]   = pc_q;
            buf_inst_d[wr_ptr_q] = ip_inst_from_imem;
            wr_ptr_d             = wr_ptr_q + 1'b1;
            pc_d                 = pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge ip_clk) begin
      if (ip_reset) begin
         pc_q     <= RESET_PC;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         pc_q     <= pc_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Buffer storage; contents are don't-care while count is zero, so no reset.
   always_ff @(posedge ip_clk) begin
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
   end

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign op_fetch_count = fetch_cnt_q;
   assign op_stall_count = stall_cnt_q;

   // Counter next-state: fetches on push, stalls when fetch wanted but blocked.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (push) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (ip_fetch_en & ~ip_redirect_valid & ~push) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge ip_clk) begin
      if (ip_reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: stimulus updates a queue-based reference model,
// a negedge monitor compares DUT outputs against it.
module tb_ifetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int unsigned DEPTH  = 2;

   logic        ip_clk = 1'b0;
   logic        ip_reset = 1'b1;
   logic        ip_fetch_en = 1'b0;
   logic [31:0] op_inst_addr;
   logic        ip_inst_valid = 1'b0;
   logic [31:0] ip_inst_from_imem;
   logic        ip_redirect_valid = 1'b0;
   logic [31:0] ip_redirect_pc = '0;
   logic        op_dec_valid;
   logic [31:0] op_dec_inst;
   logic [31:0] op_dec_pc;
   logic        ip_dec_ready = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] op_fetch_count;
   logic [31:0] op_stall_count;
`endif

   always #5 ip_clk = ~ip_clk;

   // Combinational instruction memory.
   assign ip_inst_from_imem = op_inst_addr ^ 32'hA5A5_0000;

   ifetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
      .ip_clk(ip_clk),
      .ip_reset(ip_reset),
      .ip_fetch_en(ip_fetch_en),
      .op_inst_addr(op_inst_addr),
      .ip_inst_valid(ip_inst_valid),
      .ip_inst_from_imem(ip_inst_from_imem),
      .ip_redirect_valid(ip_redirect_valid),
      .ip_redirect_pc(ip_redirect_pc),
      .op_dec_valid(op_dec_valid),
      .op_dec_inst(op_dec_inst),
      .op_dec_pc(op_dec_pc),
`ifdef IFETCH_PERF_CNT_EN
      .op_fetch_count(op_fetch_count),
      .op_stall_count(op_stall_count),
`endif
      .ip_dec_ready(ip_dec_ready)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t      sb[$];
   logic [31:0] mpc = '0;
   logic [31:0] m_fetch = '0;
   logic [31:0] m_stall = '0;
   bit          chk = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; the model is advanced with what this cycle decided.
   task automatic step(input bit rst, input bit en, input bit iv, input bit rd,
                       input bit redir, input logic [31:0] rpc);
      bit p_push, p_stall;
      ip_reset          = rst;
      ip_fetch_en       = en;
      ip_inst_valid     = iv;
      ip_dec_ready      = rd;
      ip_redirect_valid = redir;
      ip_redirect_pc    = rpc;
      p_push  = en && iv && (sb.size() < DEPTH) && !redir;
      p_stall = en && !redir && !p_push;
      @(posedge ip_clk);
      #1;
      if (rst) begin
         sb.delete();
         mpc     = RST_PC;
         m_fetch = '0;
         m_stall = '0;
         chk     = 1'b1;
      end else begin
         if (redir) begin
            sb.delete();
            mpc = {rpc[31:2], 2'b00};
         end else if (p_push) begin
            sb.push_back('{pc: mpc, inst: mpc ^ 32'hA5A5_0000});
            mpc = mpc + 32'd4;
         end
         if (p_push)  m_fetch = m_fetch + 32'd1;
         if (p_stall) m_stall = m_stall + 32'd1;
      end
   endtask

   // Monitor: compares presented outputs to the model, pops on accept.
   always @(negedge ip_clk) begin
      if (chk) begin
         check("inst_addr", op_inst_addr, mpc);
         check("dec_valid", {31'd0, op_dec_valid}, {31'd0, sb.size() != 0});
         if (op_dec_valid && sb.size() > 0) begin
            check("dec_pc", op_dec_pc, sb[0].pc);
            check("dec_inst", op_dec_inst, sb[0].inst);
            if (ip_dec_ready) void'(sb.pop_front());
         end
`ifdef IFETCH_PERF_CNT_EN
         check("fetch_count", op_fetch_count, m_fetch);
         check("stall_count", op_stall_count, m_stall);
`endif
      end
   end

   initial begin
      step(1, 0, 0, 0, 0, '0);
      step(1, 0, 0, 0, 0, '0);
      // Streaming with decode always ready.
      for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 0, '0);
      // Decode back-pressure fills the buffer, then drains in order.
      step(1, 0, 0, 0, 0, '0);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, '0);
      @(negedge ip_clk);
      check("full_addr_hold", op_inst_addr, 32'h0000_0008);
      check("full_head_pc", op_dec_pc, 32'h0000_0000);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, '0);
      // Redirect while full; low target bits dropped.
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, '0);
      step(0, 1, 1, 1, 1, 32'h0000_0103);
      @(negedge ip_clk);
      check("redir_valid", {31'd0, op_dec_valid}, 32'd0);
      check("redir_addr", op_inst_addr, 32'h0000_0100);
      step(0, 1, 1, 1, 0, '0);
      @(negedge ip_clk);
      check("redir_first_pc", op_dec_pc, 32'h0000_0100);
      // Memory valid toggling.
      for (int i = 0; i < 8; i++) step(0, 1, (i % 2) == 0, 1, 0, '0);
      // PC wrap at the top of the address space.
      step(0, 1, 1, 1, 1, 32'hFFFF_FFF8);
      step(0, 1, 1, 1, 0, '0);
      step(0, 1, 1, 1, 0, '0);
      @(negedge ip_clk);
      check("wrap_addr", op_inst_addr, 32'h0000_0000);
      // Reset with the buffer full.
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, '0);
      step(1, 1, 1, 0, 0, '0);
      @(negedge ip_clk);
      check("rst_valid", {31'd0, op_dec_valid}, 32'd0);
      check("rst_addr", op_inst_addr, RST_PC);
      // Redirect with fetch disabled, then resume.
      step(0, 0, 1, 1, 1, 32'h0000_2000);
      step(0, 0, 1, 1, 0, '0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, '0);
`ifdef IFETCH_PERF_CNT_EN
      step(1, 0, 0, 0, 0, '0);
      for (int i = 0; i < 9; i++) step(0, 1, 1, 1, 0, '0);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, '0);
      @(negedge ip_clk);
      check("perf_fetch10", op_fetch_count, 32'd10);
      check("perf_stall3", op_stall_count, 32'd3);
`endif
      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bit r_rst, r_red;
         r_rst = ($urandom_range(63) == 0);
         r_red = ($urandom_range(15) == 0);
         step(r_rst, $urandom_range(7) != 0, $urandom_range(3) != 0,
              $urandom_range(2) != 0, r_red, $urandom);
      end
      @(negedge ip_clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
